// File: rtl/cdma_pkg.sv
// Shared definitions for the CDMA lite sequencer: register map, status bits, FSM encoding.
package cdma_pkg;

  localparam logic [31:0] CDMA_SR_OFS  = 32'h0000_0004;
  localparam logic [31:0] CDMA_SA_OFS  = 32'h0000_0018;
  localparam logic [31:0] CDMA_DA_OFS  = 32'h0000_0020;
  localparam logic [31:0] CDMA_BTT_OFS = 32'h0000_0028;

  localparam int SR_IDLE_BIT    = 1;
  localparam int SR_ERR_LSB     = 4;
  localparam int SR_ERR_MSB     = 6;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [3:0] WSTRB_ALL = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_SA   = 3'd1,
    WR_DA   = 3'd2,
    WR_BTT  = 3'd3,
    POLL_AR = 3'd4,
    POLL_R  = 3'd5,
    DONE    = 3'd6
  } cdma_state_t;

  function automatic logic [31:0] btt_word(input logic [22:0] btt);
    return {9'd0, btt};
  endfunction

endpackage

// File: rtl/axil_single_wr.sv
// One-beat AXI4-Lite write engine: launches AW and W together, each retires on its own
// handshake, then accepts the B response once both have completed.
module axil_single_wr
  import cdma_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        done,
  output logic [1:0]  resp
);

  logic busy;
  logic aw_done;
  logic w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awaddr  <= '0;
      wdata   <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      busy    <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (start) begin
      awaddr  <= addr;
      wdata   <= data;
      awvalid <= 1'b1;
      wvalid  <= 1'b1;
      busy    <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        awvalid <= 1'b0;
        aw_done <= 1'b1;
      end
      if (wvalid && wready) begin
        wvalid <= 1'b0;
        w_done <= 1'b1;
      end
      if (done) begin
        busy    <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  // Strobes are only driven while a beat is offered so the bus idles at zero.
  assign wstrb  = wvalid ? WSTRB_ALL : 4'h0;
  assign bready = busy & aw_done & w_done;
  assign done   = bready & bvalid;
  assign resp   = bresp;

endmodule

// File: rtl/cdma_lite_seq.sv
// Programs an AXI CDMA for one simple-mode transfer (SA, DA, BTT) over AXI4-Lite and
// polls CDMASR until the engine goes idle, a bus error occurs or the poll budget runs out.
//
// state   | meaning
// IDLE    | after reset, waiting for an INIT_TXN rising edge
// WR_SA   | writing source address
// WR_DA   | writing destination address
// WR_BTT  | writing byte count (starts the CDMA)
// POLL_AR | issuing a CDMASR read
// POLL_R  | waiting for CDMASR read data
// DONE    | transfer finished, TXN_DONE high, ERROR valid
module cdma_lite_seq
  import cdma_pkg::*;
#(
  parameter logic [31:0] C_CDMA_BASE  = 32'h0000_0000,
  parameter int          C_POLL_LIMIT = 1024
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        INIT_TXN,
  input  logic [31:0] SRC_ADDR,
  input  logic [31:0] DST_ADDR,
  input  logic [22:0] BTT,
  output logic        TXN_DONE,
  output logic        ERROR,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  localparam logic [15:0] POLL_LIM = 16'(C_POLL_LIMIT);

  cdma_state_t state, state_nxt;

  logic        init_q;
  logic        start;
  logic [31:0] dst_q;
  logic [22:0] btt_q;
  logic [15:0] poll_cnt;
  logic        error_q, error_nxt;

  logic        wr_start;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_done;
  logic [1:0]  wr_resp;

  logic        sr_idle;
  logic        sr_err;
  logic        unused_rdata;

  assign start   = INIT_TXN & ~init_q & ((state == IDLE) | (state == DONE));
  assign sr_idle = M_AXI_RDATA[SR_IDLE_BIT];
  assign sr_err  = |M_AXI_RDATA[SR_ERR_MSB:SR_ERR_LSB];
  assign unused_rdata = ^{M_AXI_RDATA[31:7], M_AXI_RDATA[3:2], M_AXI_RDATA[0]};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    error_nxt = error_q;
    wr_start  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (BTT == '0) begin
            state_nxt = DONE;
            error_nxt = 1'b1;
          end else begin
            state_nxt = WR_SA;
            error_nxt = 1'b0;
            wr_start  = 1'b1;
            wr_addr   = C_CDMA_BASE + CDMA_SA_OFS;
            wr_data   = SRC_ADDR;
          end
        end
      end
      WR_SA: begin
        if (wr_done) begin
          if (wr_resp != RESP_OKAY) begin
            state_nxt = DONE;
            error_nxt = 1'b1;
          end else begin
            state_nxt = WR_DA;
            wr_start  = 1'b1;
            wr_addr   = C_CDMA_BASE + CDMA_DA_OFS;
            wr_data   = dst_q;
          end
        end
      end
      WR_DA: begin
        if (wr_done) begin
          if (wr_resp != RESP_OKAY) begin
            state_nxt = DONE;
            error_nxt = 1'b1;
          end else begin
            state_nxt = WR_BTT;
            wr_start  = 1'b1;
            wr_addr   = C_CDMA_BASE + CDMA_BTT_OFS;
            wr_data   = btt_word(btt_q);
          end
        end
      end
      WR_BTT: begin
        if (wr_done) begin
          if (wr_resp != RESP_OKAY) begin
            state_nxt = DONE;
            error_nxt = 1'b1;
          end else begin
            state_nxt = POLL_AR;
          end
        end
      end
      POLL_AR: begin
        if (M_AXI_ARREADY) begin
          state_nxt = POLL_R;
        end
      end
      POLL_R: begin
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != RESP_OKAY) begin
            state_nxt = DONE;
            error_nxt = 1'b1;
          end else if (sr_idle) begin
            state_nxt = DONE;
            error_nxt = sr_err;
          end else if (poll_cnt >= POLL_LIM) begin
            state_nxt = DONE;
            error_nxt = 1'b1;
          end else begin
            state_nxt = POLL_AR;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // init_q resets high so a level held through reset is not mistaken for a new edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      init_q   <= 1'b1;
      dst_q    <= '0;
      btt_q    <= '0;
      poll_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      init_q  <= INIT_TXN;
      error_q <= error_nxt;
      if (start) begin
        dst_q    <= DST_ADDR;
        btt_q    <= BTT;
        poll_cnt <= '0;
      end else if ((state == POLL_AR) && M_AXI_ARREADY) begin
        poll_cnt <= poll_cnt + 16'd1;
      end
    end
  end

  axil_single_wr u_wr (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .start   (wr_start),
    .addr    (wr_addr),
    .data    (wr_data),
    .awaddr  (M_AXI_AWADDR),
    .awvalid (M_AXI_AWVALID),
    .awready (M_AXI_AWREADY),
    .wdata   (M_AXI_WDATA),
    .wstrb   (M_AXI_WSTRB),
    .wvalid  (M_AXI_WVALID),
    .wready  (M_AXI_WREADY),
    .bresp   (M_AXI_BRESP),
    .bvalid  (M_AXI_BVALID),
    .bready  (M_AXI_BREADY),
    .done    (wr_done),
    .resp    (wr_resp)
  );

  assign M_AXI_ARVALID = (state == POLL_AR);
  assign M_AXI_ARADDR  = M_AXI_ARVALID ? (C_CDMA_BASE + CDMA_SR_OFS) : 32'h0;
  assign M_AXI_RREADY  = (state == POLL_R);
  assign TXN_DONE      = (state == DONE);
  assign ERROR         = error_q;

endmodule

// File: tb/tb_cdma_lite_seq.sv
// Directed bench for cdma_lite_seq: reactive AXI4-Lite slave plus hand-computed expectations.
module tb_cdma_lite_seq;

  logic        tb_ACLK = 1'b0;
  logic        ARESETN;
  logic        INIT_TXN;
  logic [31:0] SRC_ADDR, DST_ADDR;
  logic [22:0] BTT;
  logic        TXN_DONE, ERROR;
  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID, M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  always #5 tb_ACLK = ~tb_ACLK;

  cdma_lite_seq #(.C_CDMA_BASE(32'h0000_0000), .C_POLL_LIMIT(8)) dut (
    .ACLK(tb_ACLK), .ARESETN(ARESETN), .INIT_TXN(INIT_TXN),
    .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .BTT(BTT),
    .TXN_DONE(TXN_DONE), .ERROR(ERROR),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  wire [106:0] all_outs = {TXN_DONE, ERROR, M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA,
                           M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARADDR,
                           M_AXI_ARVALID, M_AXI_RREADY};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // slave configuration (written by the stimulus process only)
  int         aw_delay;
  int         b_err_idx;
  int         sr_idle_at;
  logic [2:0] sr_err;
  logic       log_clr;

  // slave log (written by the slave process only)
  int          naw, nwd, nb, nbh, nr, nvalid, ra_bad, wstrb_bad, bready_bad, cyc, aw_cyc0, w_cyc0;
  logic [31:0] wa [16];
  logic [31:0] wd [16];
  int          aw_cnt;
  logic        r_pend;
  logic        p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  // Slave acts on negedges: first retires handshakes made at the previous posedge,
  // then sets up its drives for the next posedge.
  initial begin
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
    cyc = 0;
    forever begin
      @(negedge tb_ACLK);
      cyc++;
      if (!ARESETN || log_clr) begin
        naw = 0; nwd = 0; nb = 0; nbh = 0; nr = 0; nvalid = 0; ra_bad = 0; wstrb_bad = 0;
        bready_bad = 0; aw_cyc0 = 0; w_cyc0 = 0; aw_cnt = 0; r_pend = 0;
        for (int i = 0; i < 16; i++) begin wa[i] = '0; wd[i] = '0; end
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_bv = 0; p_br = 0;
        p_arv = 0; p_arr = 0; p_rv = 0; p_rr = 0;
        p_awaddr = 0; p_wdata = 0; p_araddr = 0;
        continue;
      end
      if (p_awv && p_awr) begin
        if (naw < 16) wa[naw] = p_awaddr;
        if (naw == 0) aw_cyc0 = cyc;
        naw++;
        aw_cnt = 0;
      end
      if (p_wv && p_wr) begin
        if (nwd < 16) wd[nwd] = p_wdata;
        if (nwd == 0) w_cyc0 = cyc;
        nwd++;
      end
      if (p_bv && p_br) begin
        M_AXI_BVALID = 0;
        nbh++;
      end
      if (p_arv && p_arr) begin
        if (p_araddr != 32'h4) ra_bad++;
        nr++;
        r_pend = 1;
      end
      if (p_rv && p_rr) M_AXI_RVALID = 0;

      if (!M_AXI_BVALID && naw > nb && nwd > nb) begin
        M_AXI_BVALID = 1;
        M_AXI_BRESP  = (nb == b_err_idx) ? 2'b10 : 2'b00;
        nb++;
      end
      if (r_pend && !M_AXI_RVALID) begin
        M_AXI_RVALID = 1;
        M_AXI_RRESP  = 2'b00;
        M_AXI_RDATA  = (sr_idle_at != 0 && nr >= sr_idle_at) ?
                       ({25'd0, sr_err, 4'b0} | 32'h2) : 32'h0;
        r_pend = 0;
      end
      M_AXI_AWREADY = (aw_cnt >= aw_delay);
      if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_cnt++;
      M_AXI_WREADY  = 1;
      M_AXI_ARREADY = 1;

      if (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_ARVALID) nvalid++;
      if (M_AXI_WVALID && M_AXI_WSTRB != 4'hF) wstrb_bad++;
      if (M_AXI_BREADY && !(naw > nbh && nwd > nbh)) bready_bad++;

      p_awv = M_AXI_AWVALID; p_awr = M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
      p_wv  = M_AXI_WVALID;  p_wr  = M_AXI_WREADY;  p_wdata  = M_AXI_WDATA;
      p_bv  = M_AXI_BVALID;  p_br  = M_AXI_BREADY;
      p_arv = M_AXI_ARVALID; p_arr = M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
      p_rv  = M_AXI_RVALID;  p_rr  = M_AXI_RREADY;
    end
  end

  task automatic cfg(input int awd, input int berr, input int idle_at, input logic [2:0] serr);
    aw_delay = awd; b_err_idx = berr; sr_idle_at = idle_at; sr_err = serr;
  endtask

  task automatic clr_log();
    @(negedge tb_ACLK); #1 log_clr = 1;
    @(negedge tb_ACLK); #1 log_clr = 0;
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [22:0] b);
    @(negedge tb_ACLK); #1;
    SRC_ADDR = s; DST_ADDR = d; BTT = b; INIT_TXN = 1;
    @(negedge tb_ACLK); #1 INIT_TXN = 0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!TXN_DONE && n < 400) begin
      @(negedge tb_ACLK); #1;
      n++;
    end
    if (!TXN_DONE) chk({tag, "_timeout"}, 0, 1);
    repeat (2) @(negedge tb_ACLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ARESETN = 0; INIT_TXN = 0; SRC_ADDR = 0; DST_ADDR = 0; BTT = 0; log_clr = 0;
    cfg(0, -1, 0, 3'd0);
    repeat (3) @(negedge tb_ACLK);
    #1 chk("rst_outs", 128'(all_outs), 0);
    ARESETN = 1;
    repeat (2) @(negedge tb_ACLK);
    #1 chk("idle_done", TXN_DONE, 0);

    // basic transfer, idle on the 3rd status read
    clr_log(); cfg(0, -1, 3, 3'd0);
    pulse_start(32'h1000, 32'h2000, 23'd256);
    wait_done("t1");
    chk("t1_naw", naw, 3);
    chk("t1_wa0", wa[0], 32'h18);
    chk("t1_wd0", wd[0], 32'h1000);
    chk("t1_wa1", wa[1], 32'h20);
    chk("t1_wd1", wd[1], 32'h2000);
    chk("t1_wa2", wa[2], 32'h28);
    chk("t1_wd2", wd[2], 32'h100);
    chk("t1_nr", nr, 3);
    chk("t1_raddr", ra_bad, 0);
    chk("t1_wstrb", wstrb_bad, 0);
    chk("t1_done", TXN_DONE, 1);
    chk("t1_err", ERROR, 0);

    // AWREADY late by 3 cycles, WREADY immediate, max BTT
    clr_log(); cfg(3, -1, 1, 3'd0);
    pulse_start(32'hA5A5_0000, 32'h5A5A_1111, 23'h7F_FFFF);
    wait_done("t2");
    chk("t2_w_first", (w_cyc0 < aw_cyc0), 1);
    chk("t2_aw_lag", aw_cyc0 - w_cyc0, 3);
    chk("t2_bready", bready_bad, 0);
    chk("t2_wd0", wd[0], 32'hA5A5_0000);
    chk("t2_wd1", wd[1], 32'h5A5A_1111);
    chk("t2_wd2", wd[2], 32'h007F_FFFF);
    chk("t2_err", ERROR, 0);
    chk("t2_nr", nr, 1);

    // SLVERR on DA write
    clr_log(); cfg(0, 1, 1, 3'd0);
    pulse_start(32'h3000, 32'h4000, 23'd16);
    wait_done("t3");
    chk("t3_naw", naw, 2);
    chk("t3_nr", nr, 0);
    chk("t3_done", TXN_DONE, 1);
    chk("t3_err", ERROR, 1);

    // idle with an error bit in CDMASR
    clr_log(); cfg(0, -1, 2, 3'b001);
    pulse_start(32'h10, 32'h20, 23'd4);
    wait_done("t4");
    chk("t4_nr", nr, 2);
    chk("t4_err", ERROR, 1);

    // never idle: poll budget of 8
    clr_log(); cfg(0, -1, 0, 3'd0);
    pulse_start(32'h10, 32'h20, 23'd4);
    wait_done("t5");
    chk("t5_nr", nr, 8);
    chk("t5_done", TXN_DONE, 1);
    chk("t5_err", ERROR, 1);

    // BTT of zero: no bus traffic
    clr_log(); cfg(0, -1, 1, 3'd0);
    pulse_start(32'h10, 32'h20, 23'd0);
    wait_done("t6");
    chk("t6_done", TXN_DONE, 1);
    chk("t6_err", ERROR, 1);
    chk("t6_valids", nvalid, 0);

    // INIT_TXN edge during polling is ignored
    clr_log(); cfg(0, -1, 0, 3'd0);
    pulse_start(32'h10, 32'h20, 23'd8);
    n = 0;
    while (nr < 2 && n < 200) begin @(negedge tb_ACLK); #1; n++; end
    chk("t7_reached_poll", (nr >= 2), 1);
    INIT_TXN = 1;
    @(negedge tb_ACLK); #1 INIT_TXN = 0;
    wait_done("t7");
    chk("t7_naw", naw, 3);
    chk("t7_nr", nr, 8);
    chk("t7_err", ERROR, 1);

    // reset during the DA write, then a clean run
    clr_log(); cfg(0, -1, 1, 3'd0);
    pulse_start(32'h7000, 32'h8000, 23'd32);
    n = 0;
    while (!(M_AXI_AWVALID && M_AXI_AWADDR == 32'h20) && n < 50) begin
      @(negedge tb_ACLK); #1; n++;
    end
    chk("t8_in_da", (M_AXI_AWVALID && M_AXI_AWADDR == 32'h20), 1);
    ARESETN = 0;
    #1 chk("t8_rst_outs", 128'(all_outs), 0);
    @(negedge tb_ACLK); #1 ARESETN = 1;
    repeat (3) @(negedge tb_ACLK);
    #1 chk("t8_post_idle", {TXN_DONE, M_AXI_AWVALID, M_AXI_ARVALID}, 0);
    clr_log(); cfg(0, -1, 1, 3'd0);
    pulse_start(32'h9000, 32'hA000, 23'd64);
    wait_done("t8");
    chk("t8_naw", naw, 3);
    chk("t8_wd0", wd[0], 32'h9000);
    chk("t8_wa2", wa[2], 32'h28);
    chk("t8_wd2", wd[2], 32'h40);
    chk("t8_nr", nr, 1);
    chk("t8_err", ERROR, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdma_lite_seq.md
CDMA_LITE_SEQ -- requirements
Module: cdma_lite_seq

Interface
REQ-001 Parameter C_CDMA_BASE, default 32'h0000_0000: base address of the AXI CDMA register space.
REQ-002 Parameter C_POLL_LIMIT, default 1024: maximum number of status reads before a timeout.
REQ-003 ACLK  in  1  single clock; all logic is on the rising edge.
REQ-004 ARESETN  in  1  asynchronous, active-low reset.
REQ-005 INIT_TXN  in  1  start request; a rising edge launches one transfer.
REQ-006 SRC_ADDR  in  32  source address, latched at start.
REQ-007 DST_ADDR  in  32  destination address, latched at start.
REQ-008 BTT  in  23  bytes to transfer, latched at start.
REQ-009 TXN_DONE  out  1  transfer finished; level output.
REQ-010 ERROR  out  1  finished transfer failed; valid while TXN_DONE=1.
REQ-011 M_AXI_AWADDR out 32 / AWVALID out 1 / AWREADY in 1  AXI4-Lite write address channel.
REQ-012 M_AXI_WDATA out 32 / WSTRB out 4 / WVALID out 1 / WREADY in 1  AXI4-Lite write data channel.
REQ-013 M_AXI_BRESP in 2 / BVALID in 1 / BREADY out 1  AXI4-Lite write response channel.
REQ-014 M_AXI_ARADDR out 32 / ARVALID out 1 / ARREADY in 1  AXI4-Lite read address channel.
REQ-015 M_AXI_RDATA in 32 / RRESP in 2 / RVALID in 1 / RREADY out 1  AXI4-Lite read data channel.

Function
REQ-016 The FSM states SHALL be IDLE, WR_SA, WR_DA, WR_BTT, POLL_AR, POLL_R and DONE.
REQ-017 A start SHALL be an INIT_TXN sample of 1 following a sample of 0 (a registered edge detect), and SHALL be accepted only in IDLE or DONE; in every other state it is ignored.
REQ-018 On an accepted start at edge k: SRC_ADDR, DST_ADDR and BTT are latched, TXN_DONE and ERROR clear, and the FSM enters WR_SA with AWVALID=WVALID=1 from edge k.
REQ-019 The write sequence SHALL be: SA to base+0x18, DA to base+0x20, then BTT (zero-extended) to base+0x28; WSTRB is always 4'hF.
REQ-020 For each write, AWVALID and WVALID SHALL assert together, and each SHALL drop independently on its own VALID&READY.
REQ-021 BREADY SHALL be 1 only after both AW and W have handshaked; on BVALID the FSM advances.
REQ-022 A BRESP other than 2'b00 SHALL set ERROR and go to DONE, with no further writes.
REQ-023 POLL_AR SHALL issue a read of base+0x04 (CDMASR). POLL_R SHALL hold RREADY=1 and, on RVALID:
- RRESP other than 0 → ERROR, go to DONE.
- RDATA[1]=1 (idle) → ERROR=|RDATA[6:4], go to DONE.
- otherwise → reissue the read.
REQ-024 A 16-bit poll counter SHALL increment on each read. When it reaches C_POLL_LIMIT without idle: ERROR=1, go to DONE.
REQ-025 BTT=0 at start SHALL go directly to DONE with ERROR=1 and no AXI traffic.
REQ-026 DONE SHALL hold TXN_DONE=1 until the next accepted start.
REQ-027 Slave READY asserted before VALID SHALL be tolerated; VALID never depends on READY.

Reset
REQ-028 While ARESETN=0, all outputs SHALL be 0 and the FSM SHALL be IDLE. Reset mid-transaction SHALL abandon the transaction; after release the block waits for a new INIT_TXN edge.

Structure
REQ-029 The CDMA register offsets (SR=0x04, SA=0x18, DA=0x20, BTT=0x28), the status bit indices and the state encoding SHALL live in a shared package, cdma_pkg.
REQ-030 One sub-module, axil_single_wr (a one-beat AW/W/B engine), SHALL be used for the three writes; reads stay inline.

Verification
REQ-031 SRC=0x1000, DST=0x2000, BTT=256, slave always ready, SR idle on the 3rd read → writes at 0x18/0x20/0x28, 3 reads of 0x04, TXN_DONE=1, ERROR=0.
REQ-032 AWREADY delayed 3 cycles while WREADY is immediate → WVALID drops first, BREADY only after AW handshake, correct data.
REQ-033 BRESP=2'b10 on the DA write → no BTT write, TXN_DONE=1, ERROR=1.
REQ-034 SR returns idle with bit 4 set → ERROR=1; with C_POLL_LIMIT=8 and never idle → exactly 8 reads, then ERROR=1.
REQ-035 BTT=0 → TXN_DONE=1, ERROR=1, zero VALIDs; INIT_TXN toggled mid-poll → ignored.
REQ-036 ARESETN pulsed low during WR_DA → all outputs 0; a new start runs a clean full sequence.
